// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the riscv8bit data-memory responder: default
// widths and the state encodings of the main (sweep/run) and host FSMs.
package riscv8bit_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } main_state_e;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_ACK  = 1'b1
  } host_state_e;

endpackage

// File: rtl/data_ram_responder_if.sv
// Bundle of the core load/store strobes, the host req/ack port and the
// busy flag. The responder takes the slave view, the driver the master view.
interface data_ram_responder_if
  import riscv8bit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              busy;

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    input  host_req, host_we, host_addr, host_wdata,
    output rdata, host_ack, host_rdata, busy
  );

  modport master (
    output mem_read, mem_write, addr, wdata,
    output host_req, host_we, host_addr, host_wdata,
    input  rdata, host_ack, host_rdata, busy
  );

endinterface

// File: rtl/data_ram_responder_array.sv
// DEPTH x DATA_W storage: one write port committed on the clock edge and one
// read port whose data is captured by the requester's register on that same
// edge, so every read is synchronous end to end.
module data_ram_array
  import riscv8bit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Commit the single write port on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_ram_responder.sv
// Data-port memory responder for the riscv8bit core. The core owns the array
// whenever it strobes; the host req/ack port uses the idle cycles.
// Optional macro DATA_RAM_INIT_SWEEP_EN: when defined, a zero-fill sweep runs
// after reset (busy=1 for DEPTH cycles); otherwise the block starts in RUN.
module data_ram_responder
  import riscv8bit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  data_ram_responder_if.slave  bus
);

`ifdef DATA_RAM_INIT_SWEEP_EN
  localparam main_state_e RST_STATE = INIT;
  localparam logic        RST_BUSY  = 1'b1;
`else
  localparam main_state_e RST_STATE = RUN;
  localparam logic        RST_BUSY  = 1'b0;
`endif

  main_state_e       state_q, state_d;
  host_state_e       hstate_q, hstate_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_ack_q, host_ack_d;

  logic              host_go;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [ADDR_W-1:0] arr_raddr;
  logic [DATA_W-1:0] arr_rdata;

  // Host is served only in RUN, on a core-idle cycle, and never back-to-back
  // with its own ack.
  assign host_go = (state_q == RUN) && !bus.mem_read && !bus.mem_write &&
                   bus.host_req && (hstate_q == H_IDLE);

  // Read address kept outside the next-state block so the array read is not
  // folded into a combinational loop.
  assign arr_raddr = (host_go && !bus.host_we) ? bus.host_addr : bus.addr;

  data_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  // Next-state and array-port muxing for sweep, core and host.
  always_comb begin
    state_d      = state_q;
    hstate_d     = H_IDLE;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    rdata_d      = rdata_q;
    host_rdata_d = host_rdata_q;
    host_ack_d   = 1'b0;
    arr_we       = 1'b0;
    arr_waddr    = bus.addr;
    arr_wdata    = bus.wdata;
    case (state_q)
      INIT: begin
        arr_we    = 1'b1;
        arr_waddr = cnt_q;
        arr_wdata = {DATA_W{1'b0}};
        cnt_d     = cnt_q + ADDR_W'(1);
        if (bus.mem_read) begin
          rdata_d = {DATA_W{1'b0}};
        end else begin
          rdata_d = rdata_q;
        end
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end else begin
          state_d = INIT;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b0;
        if (bus.mem_read || bus.mem_write) begin
          arr_we = bus.mem_write;
          if (bus.mem_read && bus.mem_write) begin
            rdata_d = bus.wdata;
          end else if (bus.mem_read) begin
            rdata_d = arr_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (host_go) begin
          hstate_d   = H_ACK;
          host_ack_d = 1'b1;
          if (bus.host_we) begin
            arr_we    = 1'b1;
            arr_waddr = bus.host_addr;
            arr_wdata = bus.host_wdata;
          end else begin
            host_rdata_d = arr_rdata;
          end
        end else begin
          hstate_d = H_IDLE;
        end
      end
      default: begin
        state_d = RST_STATE;
        busy_d  = RST_BUSY;
      end
    endcase
  end

  // State and registered outputs; reset aborts everything, including a pending ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RST_STATE;
      hstate_q     <= H_IDLE;
      cnt_q        <= {ADDR_W{1'b0}};
      busy_q       <= RST_BUSY;
      rdata_q      <= {DATA_W{1'b0}};
      host_rdata_q <= {DATA_W{1'b0}};
      host_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hstate_q     <= hstate_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      rdata_q      <= rdata_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed, table-driven bench for data_ram_responder. Honours
// DATA_RAM_INIT_SWEEP_EN so the same bench covers both builds.
module tb_data_ram_responder;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic       hreq;
    logic       hwe;
    logic [7:0] ha;
    logic [7:0] hd;
    logic [7:0] e_rdata;
    logic       e_ack;
    logic [7:0] e_hr;
  } vec_t;

`ifdef DATA_RAM_INIT_SWEEP_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt = 0;
  vec_t tbl [24];

  always #5 clk = ~clk;

  data_ram_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  data_ram_responder #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.addr       = 8'h00;
    bus.wdata      = 8'h00;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 8'h00;
    bus.host_wdata = 8'h00;
  endtask

`ifdef DATA_RAM_INIT_SWEEP_EN
  // Count busy cycles from reset release while a host read of 0xFF waits and
  // the core tries a store/load to 0x00 mid-sweep; then finish the host read.
  task automatic sweep(input string tag);
    int n = 0;
    int acks = 0;
    int nz = 0;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 8'hFF;
    bus.addr      = 8'h00;
    bus.wdata     = 8'h99;
    while (bus.busy === 1'b1 && n < 400) begin
      bus.mem_read  = (n >= 5 && n < 10);
      bus.mem_write = (n >= 5 && n < 10);
      if (bus.host_ack !== 1'b0) acks++;
      if (bus.rdata !== 8'h00) nz++;
      n++;
      cyc();
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    chk({tag, " busy cycles"}, 16'(n), 16'd256);
    chk({tag, " ack during sweep"}, 16'(acks), 16'd0);
    chk({tag, " rdata during sweep"}, 16'(nz), 16'd0);
    chk({tag, " ack at busy fall"}, 16'(bus.host_ack), 16'd0);
    cyc();
    chk({tag, " host ack FF"}, 16'(bus.host_ack), 16'd1);
    chk({tag, " host rdata FF"}, 16'(bus.host_rdata), 16'h00);
    idle();
    cyc();
    chk({tag, " ack single"}, 16'(bus.host_ack), 16'd0);
    bus.mem_read = 1'b1;
    bus.addr     = 8'h00;
    cyc();
    chk({tag, " dropped store"}, 16'(bus.rdata), 16'h00);
    idle();
    cyc();
  endtask
`endif

  initial begin
    //           rd    wr    a      d      hreq  hwe   ha     hd     rdata  ack   hr
    tbl[0]  = '{1'b0, 1'b1, 8'h01, 8'h34, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h34, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h34, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h34, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 8'h05, 8'hCC, 1'b0, 1'b0, 8'h00, 8'h00, 8'hCC, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 8'hCC, 1'b1, 8'hCC};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hCC, 1'b0, 8'hCC};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h0A, 8'h5A, 8'hCC, 1'b1, 8'hCC};
    tbl[8]  = '{1'b1, 1'b0, 8'h0A, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, 8'hCC};
    tbl[9]  = '{1'b0, 1'b1, 8'h10, 8'h11, 1'b1, 1'b1, 8'h20, 8'h77, 8'h5A, 1'b0, 8'hCC};
    tbl[10] = '{1'b0, 1'b1, 8'h11, 8'h22, 1'b1, 1'b1, 8'h20, 8'h77, 8'h5A, 1'b0, 8'hCC};
    tbl[11] = '{1'b0, 1'b1, 8'h12, 8'h33, 1'b1, 1'b1, 8'h20, 8'h77, 8'h5A, 1'b0, 8'hCC};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h77, 8'h5A, 1'b1, 8'hCC};
    tbl[13] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 8'hCC};
    tbl[14] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h22, 1'b0, 8'hCC};
    tbl[15] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h33, 1'b0, 8'hCC};
    tbl[16] = '{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 1'b0, 8'hCC};
    tbl[17] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, 8'h77, 1'b1, 8'h33};
    tbl[18] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h0A, 8'h00, 8'h77, 1'b0, 8'h33};
    tbl[19] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h0A, 8'h00, 8'h77, 1'b1, 8'h5A};
    tbl[20] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 1'b0, 8'h5A};
    tbl[21] = '{1'b1, 1'b0, 8'h0A, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 8'h5A, 1'b0, 8'h5A};
    tbl[22] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 8'h5A, 1'b1, 8'hCC};
    tbl[23] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, 8'hCC};

    // Reset state.
    idle();
    #2 rst = 1'b0;
    #1;
    chk("reset rdata", 16'(bus.rdata), 16'h00);
    chk("reset host_rdata", 16'(bus.host_rdata), 16'h00);
    chk("reset host_ack", 16'(bus.host_ack), 16'd0);
    chk("reset busy", 16'(bus.busy), 16'(EXP_BUSY_RST));
    repeat (3) cyc();
    rst = 1'b1;

`ifdef DATA_RAM_INIT_SWEEP_EN
    sweep("init");
`else
    chk("no-sweep busy", 16'(bus.busy), 16'd0);
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 8'hFF;
    bus.host_wdata = 8'h00;
    cyc();
    chk("no-sweep host wr ack", 16'(bus.host_ack), 16'd1);
    idle();
    cyc();
    bus.host_req  = 1'b1;
    bus.host_addr = 8'hFF;
    cyc();
    chk("no-sweep host rd ack", 16'(bus.host_ack), 16'd1);
    chk("no-sweep host rd FF", 16'(bus.host_rdata), 16'h00);
    idle();
    cyc();
`endif

    // One table row per clock: drive, clock, compare.
    for (int i = 0; i < 24; i++) begin
      bus.mem_read   = tbl[i].rd;
      bus.mem_write  = tbl[i].wr;
      bus.addr       = tbl[i].a;
      bus.wdata      = tbl[i].d;
      bus.host_req   = tbl[i].hreq;
      bus.host_we    = tbl[i].hwe;
      bus.host_addr  = tbl[i].ha;
      bus.host_wdata = tbl[i].hd;
      cyc();
      chk($sformatf("row%0d rdata", i), 16'(bus.rdata), 16'(tbl[i].e_rdata));
      chk($sformatf("row%0d host_ack", i), 16'(bus.host_ack), 16'(tbl[i].e_ack));
      chk($sformatf("row%0d host_rdata", i), 16'(bus.host_rdata), 16'(tbl[i].e_hr));
      chk($sformatf("row%0d busy", i), 16'(bus.busy), 16'd0);
    end
    idle();

    // Reset in the ack cycle of an accepted host write.
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 8'h0A;
    bus.host_wdata = 8'hEE;
    cyc();
    chk("t6 accept ack", 16'(bus.host_ack), 16'd1);
    idle();
    rst = 1'b0;
    #1;
    chk("t6 ack lost", 16'(bus.host_ack), 16'd0);
    chk("t6 rdata cleared", 16'(bus.rdata), 16'h00);
    chk("t6 host_rdata cleared", 16'(bus.host_rdata), 16'h00);
    chk("t6 busy", 16'(bus.busy), 16'(EXP_BUSY_RST));
    @(posedge clk);
    #1;
    rst = 1'b1;
`ifdef DATA_RAM_INIT_SWEEP_EN
    sweep("t6");
`endif
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 8'h0A;
    cyc();
    chk("t6 reread ack", 16'(bus.host_ack), 16'd1);
`ifdef DATA_RAM_INIT_SWEEP_EN
    chk("t6 reread 0A", 16'(bus.host_rdata), 16'h00);
`else
    chk("t6 reread 0A", 16'(bus.host_rdata), 16'hEE);
`endif
    idle();
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
